// File: rtl/ikaz_surucu.sv
// ikaz_surucu: dashboard lamp/buzzer driver with blink, beep cadence and auto-mute
module ikaz_surucu #(
    parameter int TICK_DIV        = 50000,
    parameter int BLINK_TICKS     = 500,
    parameter int KEMER_ON_TICKS  = 200,
    parameter int KEMER_OFF_TICKS = 300,
    parameter int KAPI_ON_TICKS   = 100,
    parameter int KAPI_OFF_TICKS  = 900,
    parameter int MAX_BEEPS       = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic emniyet_kemeri_lambasi,
    input  logic kapi_lambasi,
    input  logic emniyet_kemeri_ikaz,
    input  logic kapi_ikaz,
    output logic kemer_lamba_cikis,
    output logic kapi_lamba_cikis,
    output logic buzzer,
    output logic susturuldu
);
    localparam int M1   = KEMER_ON_TICKS > KEMER_OFF_TICKS ? KEMER_ON_TICKS : KEMER_OFF_TICKS;
    localparam int M2   = KAPI_ON_TICKS > KAPI_OFF_TICKS ? KAPI_ON_TICKS : KAPI_OFF_TICKS;
    localparam int M3   = M1 > M2 ? M1 : M2;
    localparam int TMAX = M3 > BLINK_TICKS ? M3 : BLINK_TICKS;
    localparam int PW   = $clog2(TMAX + 1);
    localparam int DW   = $clog2(TICK_DIV + 1);
    localparam int BW   = $clog2(MAX_BEEPS + 1);
    localparam logic [PW-1:0] BLINK_SON     = PW'(BLINK_TICKS - 1);
    localparam logic [PW-1:0] KEMER_ON_SON  = PW'(KEMER_ON_TICKS - 1);
    localparam logic [PW-1:0] KEMER_OFF_SON = PW'(KEMER_OFF_TICKS - 1);
    localparam logic [PW-1:0] KAPI_ON_SON   = PW'(KAPI_ON_TICKS - 1);
    localparam logic [PW-1:0] KAPI_OFF_SON  = PW'(KAPI_OFF_TICKS - 1);

    typedef enum logic [2:0] {
        BOS, KEMER_CAL, KEMER_BEKLE, KAPI_CAL, KAPI_BEKLE, SUSTUR
    } durum_t;

    durum_t        durum, durum_d;
    logic [DW-1:0] div_cnt;
    logic [PW-1:0] blink_cnt, faz_cnt, faz_son;
    logic [BW-1:0] beep_say;
    logic          tick, blink_faz, faz_bitti, limit_dolu, sayiyor, cal_giris, capraz;

    assign tick       = div_cnt == DW'(TICK_DIV - 1);
    assign faz_son    = durum == KEMER_CAL   ? KEMER_ON_SON  :
                        durum == KEMER_BEKLE ? KEMER_OFF_SON :
                        durum == KAPI_CAL    ? KAPI_ON_SON   : KAPI_OFF_SON;
    assign faz_bitti  = tick && faz_cnt == faz_son;
    assign limit_dolu = beep_say == BW'(MAX_BEEPS);
    assign sayiyor    = durum != BOS && durum != SUSTUR;
    assign cal_giris  = durum_d != durum && (durum_d == KEMER_CAL || durum_d == KAPI_CAL);
    assign capraz     = (durum_d == KEMER_CAL) != (durum == KEMER_CAL || durum == KEMER_BEKLE);

    // free-running millisecond prescaler
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_cnt <= '0;
        else     div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    // free-running blink phase, starts lit so lamps show immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_faz <= 1'b1;
        end else if (tick) begin
            blink_cnt <= blink_cnt == BLINK_SON ? '0 : blink_cnt + 1'b1;
            blink_faz <= blink_cnt == BLINK_SON ? ~blink_faz : blink_faz;
        end
    end

    // lamps steady on request alone, blinking when the warning is also active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kemer_lamba_cikis <= 1'b0;
            kapi_lamba_cikis  <= 1'b0;
        end else begin
            kemer_lamba_cikis <= emniyet_kemeri_lambasi & (~emniyet_kemeri_ikaz | blink_faz);
            kapi_lamba_cikis  <= kapi_lambasi & (~kapi_ikaz | blink_faz);
        end
    end

    // buzzer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) durum <= BOS;
        else     durum <= durum_d;
    end

    // phase ticks restart on every state change; beep count restarts when the source changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            faz_cnt  <= '0;
            beep_say <= '0;
        end else begin
            faz_cnt  <= durum_d != durum ? '0 : (tick && sayiyor) ? faz_cnt + 1'b1 : faz_cnt;
            beep_say <= durum_d == BOS ? '0 : cal_giris ? (capraz ? BW'(1) : beep_say + 1'b1) : beep_say;
        end
    end

    // next state: request changes override the phase-end transition; outputs decoded from state
    always_comb begin
        durum_d    = durum;
        buzzer     = durum == KEMER_CAL || durum == KAPI_CAL;
        susturuldu = durum == SUSTUR;
        case (durum)
            BOS: durum_d = emniyet_kemeri_ikaz ? KEMER_CAL : kapi_ikaz ? KAPI_CAL : BOS;
            KEMER_CAL, KEMER_BEKLE: begin
                if (!emniyet_kemeri_ikaz) durum_d = kapi_ikaz ? KAPI_CAL : BOS;
                else if (faz_bitti)       durum_d = durum == KEMER_CAL ? KEMER_BEKLE : limit_dolu ? SUSTUR : KEMER_CAL;
            end
            KAPI_CAL, KAPI_BEKLE: begin
                if (emniyet_kemeri_ikaz) durum_d = KEMER_CAL;
                else if (!kapi_ikaz)     durum_d = BOS;
                else if (faz_bitti)      durum_d = durum == KAPI_CAL ? KAPI_BEKLE : limit_dolu ? SUSTUR : KAPI_CAL;
            end
            SUSTUR:  durum_d = (emniyet_kemeri_ikaz || kapi_ikaz) ? SUSTUR : BOS;
            default: durum_d = BOS;
        endcase
    end
endmodule

// File: tb/tb_ikaz_surucu.sv
// tb_ikaz_surucu: randomized and directed checks of ikaz_surucu against a timeline model
module tb_ikaz_surucu;
    localparam int TD = 4, BT = 5, KEON = 2, KEOFF = 3, KAON = 1, KAOFF = 4, MB = 3;

    logic clk = 0, rst = 1, kl = 0, dl = 0, ki = 0, di = 0;
    logic kemer_lamba_cikis, kapi_lamba_cikis, buzzer, susturuldu;
    logic [3:0] outs, exp_v = '0;
    int pass_cnt = 0, chk_cnt = 0;
    int c = 0, m_mode = 0, m_start = 0, m_beeps = 0;
    bit m_on = 0;

    assign outs = {kemer_lamba_cikis, kapi_lamba_cikis, buzzer, susturuldu};

    always #5 clk = ~clk;

    ikaz_surucu #(
        .TICK_DIV(TD), .BLINK_TICKS(BT), .KEMER_ON_TICKS(KEON), .KEMER_OFF_TICKS(KEOFF),
        .KAPI_ON_TICKS(KAON), .KAPI_OFF_TICKS(KAOFF), .MAX_BEEPS(MB)
    ) dut (
        .clk(clk), .rst(rst),
        .emniyet_kemeri_lambasi(kl), .kapi_lambasi(dl),
        .emniyet_kemeri_ikaz(ki), .kapi_ikaz(di),
        .kemer_lamba_cikis(kemer_lamba_cikis), .kapi_lamba_cikis(kapi_lamba_cikis),
        .buzzer(buzzer), .susturuldu(susturuldu)
    );

    // Model: mode 0 idle, 1 seat belt, 2 door, 3 muted; cycle c counted from reset release.
    function automatic bit faz(input int t);
        return ((t / (TD * BT)) % 2) == 0;
    endfunction

    function automatic int ticks_in(input int a, input int b);
        return (b + 1) / TD - a / TD;
    endfunction

    task automatic enter(input int mode, input int b);
        m_mode = mode; m_on = 1; m_start = c + 1; m_beeps = b;
    endtask

    task automatic phase_end(input int mode);
        if (m_on) begin m_on = 0; m_start = c + 1; end
        else if (m_beeps == MB) m_mode = 3;
        else enter(mode, m_beeps + 1);
    endtask

    task automatic model_edge();
        int n;
        bit done, e_kl, e_dl;
        n    = m_on ? (m_mode == 1 ? KEON : KAON) : (m_mode == 1 ? KEOFF : KAOFF);
        done = (c % TD == TD - 1) && ticks_in(m_start, c) == n;
        e_kl = kl & (!ki | faz(c));
        e_dl = dl & (!di | faz(c));
        case (m_mode)
            0: if (ki) enter(1, 1); else if (di) enter(2, 1);
            1: if (!ki) begin if (di) enter(2, 1); else m_mode = 0; end
               else if (done) phase_end(1);
            2: if (ki) enter(1, 1); else if (!di) m_mode = 0; else if (done) phase_end(2);
            default: if (!ki && !di) m_mode = 0;
        endcase
        c++;
        exp_v = {e_kl, e_dl, m_on && (m_mode == 1 || m_mode == 2), m_mode == 3};
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_dut();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        c = 0; m_mode = 0; m_on = 0; m_beeps = 0; m_start = 0; exp_v = '0;
        #1;
    endtask

    task automatic test_reset();
        {kl, dl, ki, di} = 4'b1100;
        reset_dut();
        chk_cnt++;
        if (outs !== 4'b0000) $display("FAIL reset_state got=%b exp=0000", outs);
        else pass_cnt++;
        {kl, dl} = 2'b00;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk_cnt++;
            if (outs !== exp_v) $display("FAIL reset_idle c=%0d got=%b exp=%b", c, outs, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_steady_lamp();
        {kl, dl, ki, di} = 4'b0100;
        reset_dut();
        for (int i = 0; i < 200; i++) begin
            cyc();
            chk_cnt++;
            if (outs !== exp_v || (c >= 1 && outs !== 4'b0100))
                $display("FAIL steady_lamp c=%0d got=%b exp=%b", c, outs, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_blink();
        int last = -1;
        logic prev = 0;
        {kl, dl, ki, di} = 4'b1010;
        reset_dut();
        for (int i = 0; i < 130; i++) begin
            cyc();
            chk_cnt++;
            if (outs !== exp_v) $display("FAIL blink c=%0d got=%b exp=%b", c, outs, exp_v);
            else pass_cnt++;
            if (kemer_lamba_cikis !== prev) begin
                if (last > 1) begin
                    chk_cnt++;
                    if (c - last != TD * BT) $display("FAIL blink_period got=%0d exp=%0d", c - last, TD * BT);
                    else pass_cnt++;
                end
                last = c;
                prev = kemer_lamba_cikis;
            end
        end
    endtask

    task automatic test_mute();
        int rises = 0;
        logic prev = 0;
        {kl, dl, ki, di} = 4'b0010;
        reset_dut();
        for (int i = 0; i < 200 && susturuldu !== 1'b1; i++) begin
            cyc();
            chk_cnt++;
            if (outs !== exp_v) $display("FAIL mute_seq c=%0d got=%b exp=%b", c, outs, exp_v);
            else pass_cnt++;
            if (buzzer && !prev) rises++;
            prev = buzzer;
        end
        chk_cnt++;
        if (susturuldu !== 1'b1 || rises != MB) $display("FAIL mute_pulses got=%0d sus=%b exp=%0d sus=1", rises, susturuldu, MB);
        else pass_cnt++;
        ki = 0;
        cyc();
        chk_cnt++;
        if (outs !== exp_v || susturuldu !== 1'b0) $display("FAIL mute_release got=%b exp=%b", outs, exp_v);
        else pass_cnt++;
        ki = 1;
        cyc();
        chk_cnt++;
        if (outs !== exp_v || buzzer !== 1'b1) $display("FAIL mute_rearm got=%b exp=%b", outs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_preempt();
        int rises = 0;
        logic prev = 0;
        {kl, dl, ki, di} = 4'b0001;
        reset_dut();
        for (int i = 0; i < 100 && rises < 2; i++) begin
            cyc();
            chk_cnt++;
            if (outs !== exp_v) $display("FAIL preempt_door c=%0d got=%b exp=%b", c, outs, exp_v);
            else pass_cnt++;
            if (buzzer && !prev) rises++;
            prev = buzzer;
        end
        chk_cnt++;
        if (rises != 2) $display("FAIL preempt_wait got=%0d exp=2", rises);
        else pass_cnt++;
        ki = 1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            chk_cnt++;
            if (outs !== exp_v) $display("FAIL preempt_belt c=%0d got=%b exp=%b", c, outs, exp_v);
            else pass_cnt++;
        end
        chk_cnt++;
        if (susturuldu !== 1'b1) $display("FAIL preempt_mute got=%b exp=1", susturuldu);
        else pass_cnt++;
    endtask

    task automatic test_drop();
        int len = 0;
        {kl, dl, ki, di} = 4'b0011;
        reset_dut();
        for (int i = 0; i < 10 && buzzer !== 1'b1; i++) cyc();
        cyc();
        ki = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk_cnt++;
            if (outs !== exp_v) $display("FAIL drop_seq c=%0d got=%b exp=%b", c, outs, exp_v);
            else pass_cnt++;
            if (buzzer !== 1'b1) break;
            len++;
        end
        chk_cnt++;
        if (len < 1 || len > KAON * TD) $display("FAIL drop_len got=%0d exp=1..%0d", len, KAON * TD);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_beep();
        {kl, dl, ki, di} = 4'b1010;
        reset_dut();
        for (int i = 0; i < 10 && buzzer !== 1'b1; i++) cyc();
        cyc();
        rst = 1;
        #1;
        chk_cnt++;
        if (outs !== 4'b0000) $display("FAIL reset_async got=%b exp=0000", outs);
        else pass_cnt++;
        reset_dut();
        chk_cnt++;
        if (outs !== 4'b0000) $display("FAIL reset_release got=%b exp=0000", outs);
        else pass_cnt++;
        cyc();
        chk_cnt++;
        if (outs !== exp_v || buzzer !== 1'b1) $display("FAIL reset_restart got=%b exp=%b", outs, exp_v);
        else pass_cnt++;
    endtask

    task automatic test_random();
        {kl, dl, ki, di} = 4'b0000;
        reset_dut();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(11) == 0) {kl, dl, ki, di} = 4'($urandom);
            cyc();
            chk_cnt++;
            if (outs !== exp_v) $display("FAIL random c=%0d in=%b got=%b exp=%b", c, {kl, dl, ki, di}, outs, exp_v);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_steady_lamp();
        test_blink();
        test_mute();
        test_preempt();
        test_drop();
        test_reset_mid_beep();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
